// File: rtl/knn_rank_if.sv
// knn_rank_if: start/k request, per-channel fall pulses and the ranked-result bus
//   master: frame controller / upstream side (drives i_*, observes o_*)
//   slave : knn_rank itself (observes i_*, drives o_*)
// Optional o_first_idx exists only when KNN_RANK_FIRST_IDX_EN is defined.
interface knn_rank_if #(
  parameter int N_CH = 8,
  parameter int K_W  = 3
);
  localparam int CNT_W = $clog2(N_CH + 1);

  logic                 i_start;
  logic [K_W-1:0]       i_k;
  logic [N_CH-1:0]      i_fall;

  logic [N_CH-1:0]      o_nn;
  logic [N_CH-1:0]      o_knn;
  logic [CNT_W-1:0]     o_count;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_timeout;

`ifdef KNN_RANK_FIRST_IDX_EN
  localparam int IDX_W = $clog2(N_CH);
  logic [IDX_W-1:0]     o_first_idx;

  modport master (
    output i_start, i_k, i_fall,
    input  o_nn, o_knn, o_count, o_busy, o_done, o_timeout, o_first_idx
  );

  modport slave (
    input  i_start, i_k, i_fall,
    output o_nn, o_knn, o_count, o_busy, o_done, o_timeout, o_first_idx
  );
`else
  modport master (
    output i_start, i_k, i_fall,
    input  o_nn, o_knn, o_count, o_busy, o_done, o_timeout
  );

  modport slave (
    input  i_start, i_k, i_fall,
    output o_nn, o_knn, o_count, o_busy, o_done, o_timeout
  );
`endif

endinterface

// File: rtl/knn_rank.sv
// knn_rank: per-frame nearest / k-nearest detector over N_CH falling-edge channels.
// Latency: results register on the edge that samples i_fall; o_done is high the cycle after.
// Flow: no backpressure; i_start re-arms from any state, a frame ends on k reached or timeout.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   bus (slave) - i_start/i_k/i_fall in; o_nn/o_knn/o_count/o_busy/o_done/o_timeout out
// Optional: define KNN_RANK_FIRST_IDX_EN to add bus.o_first_idx (lowest set bit of o_nn).
module knn_rank #(
  parameter int N_CH  = 8,
  parameter int K_W   = 3,
  parameter int TMO_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  knn_rank_if.slave  bus
);

  localparam int CNT_W = $clog2(N_CH + 1);
  // Comparison width wide enough for both the count and the k request.
  localparam int CMP_W = (CNT_W > K_W) ? CNT_W : K_W;
  // The counter reaches all-ones on the edge that ends the last armed cycle,
  // so the hit is detected while it still holds all-ones minus one.
  localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [N_CH-1:0]   mask;
  logic [CNT_W-1:0]  cnt_q;
  logic [K_W-1:0]    k_reg;
  logic              nn_captured;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [N_CH-1:0]   nn_q;
  logic [N_CH-1:0]   knn_q;
  logic              timeout_q;

  logic [N_CH-1:0]   new_mask;
  logic [CNT_W-1:0]  new_cnt;
  logic              armed;
  logic              nn_hit;
  logic              k_hit;
  logic              tmo_hit;

  function automatic logic [CNT_W-1:0] popcnt(input logic [N_CH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_CH; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Frame datapath terms
  // ---------------------------------------------------------------------------
  always_comb begin
    armed    = (state == ARMED);
    new_mask = mask | bus.i_fall;
    new_cnt  = popcnt(new_mask);
    nn_hit   = armed && !nn_captured && (new_mask != '0);
    k_hit    = armed && (CMP_W'(new_cnt) >= CMP_W'(k_reg));
    // Reaching k on the very last armed cycle counts as a normal finish.
    tmo_hit  = armed && !k_hit && (tmo_cnt == TMO_LAST);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (bus.i_start) begin
      // Restart from any state, including mid-frame (aborted frame gets no done).
      state_nxt = ARMED;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        ARMED:   if (k_hit || tmo_hit) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.o_busy = 1'b0;
    bus.o_done = 1'b0;
    case (state)
      ARMED:   bus.o_busy = 1'b1;
      DONE:    bus.o_done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask        <= '0;
      cnt_q       <= '0;
      k_reg       <= '0;
      nn_captured <= 1'b0;
      tmo_cnt     <= '0;
      nn_q        <= '0;
      knn_q       <= '0;
      timeout_q   <= 1'b0;
    end else if (bus.i_start) begin
      // Fall pulses in the start cycle are deliberately dropped.
      mask        <= '0;
      cnt_q       <= '0;
      k_reg       <= (bus.i_k == '0) ? K_W'(1) : bus.i_k;
      nn_captured <= 1'b0;
      tmo_cnt     <= '0;
      nn_q        <= '0;
      knn_q       <= '0;
      timeout_q   <= 1'b0;
    end else if (armed) begin
      mask    <= new_mask;
      cnt_q   <= new_cnt;
      tmo_cnt <= tmo_cnt + TMO_W'(1);
      // Ties on the first arrival cycle all land in o_nn.
      if (nn_hit) begin
        nn_q        <= new_mask;
        nn_captured <= 1'b1;
      end
      // Whole mask is latched, so channels tied on the k-th arrival may push
      // popcount(o_knn) above k.
      if (k_hit) begin
        knn_q <= new_mask;
      end
      if (tmo_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.o_nn      = nn_q;
  assign bus.o_knn     = knn_q;
  assign bus.o_count   = cnt_q;
  assign bus.o_timeout = timeout_q;

`ifdef KNN_RANK_FIRST_IDX_EN
  localparam int IDX_W = $clog2(N_CH);

  logic [IDX_W-1:0] first_idx_q;
  logic [IDX_W-1:0] new_first_idx;

  // Priority scan from the top so the lowest set index wins.
  always_comb begin
    new_first_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (new_mask[i]) new_first_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_idx_q <= '0;
    end else if (bus.i_start) begin
      first_idx_q <= '0;
    end else if (nn_hit) begin
      first_idx_q <= new_first_idx;
    end
  end

  assign bus.o_first_idx = first_idx_q;
`endif

endmodule

// File: tb/tb_knn_rank.sv
// tb_knn_rank: table-driven frames with a result scoreboard, plus hand-written
// timeout, re-arm and mid-frame reset sequences for knn_rank (N_CH=8, K_W=3, TMO_W=8).
module tb_knn_rank;

  localparam int N_CH  = 8;
  localparam int K_W   = 3;
  localparam int TMO_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  knn_rank_if #(.N_CH(N_CH), .K_W(K_W)) bus ();

  knn_rank #(.N_CH(N_CH), .K_W(K_W), .TMO_W(TMO_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [K_W-1:0]    k;
    int                nf;
    logic [3:0][7:0]   fall;
    logic [7:0]        nn;
    logic [7:0]        knn;
    int                cnt;
    logic              tmo;
    int                fidx;
  } vec_t;

  vec_t vecs [6];
  vec_t sb_q [$];

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic [K_W-1:0] k, input int nf,
                              input logic [7:0] f0, input logic [7:0] f1,
                              input logic [7:0] f2, input logic [7:0] f3,
                              input logic [7:0] nn, input logic [7:0] knn,
                              input int cnt, input logic tmo, input int fidx);
    vec_t v;
    v.k    = k;
    v.nf   = nf;
    v.fall = {f3, f2, f1, f0};
    v.nn   = nn;
    v.knn  = knn;
    v.cnt  = cnt;
    v.tmo  = tmo;
    v.fidx = fidx;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [K_W-1:0] k);
    bus.i_start = 1'b1;
    bus.i_k     = k;
    bus.i_fall  = '1;
    tick();
    bus.i_start = 1'b0;
    bus.i_fall  = '0;
  endtask

  task automatic pop_check(input string tag);
    vec_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_nn"},      bus.o_nn,      e.nn);
    chk({tag, "_knn"},     bus.o_knn,     e.knn);
    chk({tag, "_count"},   bus.o_count,   e.cnt);
    chk({tag, "_timeout"}, bus.o_timeout, e.tmo);
`ifdef KNN_RANK_FIRST_IDX_EN
    chk({tag, "_first_idx"}, bus.o_first_idx, e.fidx);
`endif
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int w;
    start_frame(v.k);
    chk({tag, "_busy_after_start"},  bus.o_busy,  1);
    chk({tag, "_count_after_start"}, bus.o_count, 0);
    sb_q.push_back(v);
    for (int j = 0; j < v.nf; j++) begin
      bus.i_fall = v.fall[j];
      tick();
      chk({tag, "_done_latency"}, bus.o_done, (j == v.nf - 1) ? 1 : 0);
    end
    bus.i_fall = '0;
    w = 0;
    while (!bus.o_done && w < 10) begin
      tick();
      w++;
    end
    if (bus.o_done) begin
      pop_check(tag);
    end else begin
      chk({tag, "_done_seen"}, 0, 1);
      void'(sb_q.pop_front());
    end
    tick();
    chk({tag, "_done_single"}, bus.o_done, 0);
    chk({tag, "_idle_busy"},   bus.o_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int c;
    bus.i_start = 1'b0;
    bus.i_k     = '0;
    bus.i_fall  = '0;

    //            k  nf f0     f1     f2     f3     nn     knn    cnt tmo fidx
    vecs[0] = mk(3, 4, 8'h04, 8'h20, 8'h20, 8'h01, 8'h04, 8'h25, 3, 0, 2);
    vecs[1] = mk(2, 1, 8'h42, 8'h00, 8'h00, 8'h00, 8'h42, 8'h42, 2, 0, 1);
    vecs[2] = mk(2, 2, 8'h08, 8'h90, 8'h00, 8'h00, 8'h08, 8'h98, 3, 0, 3);
    vecs[3] = mk(0, 1, 8'h80, 8'h00, 8'h00, 8'h00, 8'h80, 8'h80, 1, 0, 7);
    vecs[4] = mk(1, 3, 8'h00, 8'h00, 8'h03, 8'h00, 8'h03, 8'h03, 2, 0, 0);
    vecs[5] = mk(4, 2, 8'h11, 8'h22, 8'h00, 8'h00, 8'h11, 8'h33, 4, 0, 0);

    // Reset state
    repeat (3) tick();
    chk("rst_nn",      bus.o_nn,      0);
    chk("rst_knn",     bus.o_knn,     0);
    chk("rst_count",   bus.o_count,   0);
    chk("rst_busy",    bus.o_busy,    0);
    chk("rst_done",    bus.o_done,    0);
    chk("rst_timeout", bus.o_timeout, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", bus.o_busy, 0);

    // Fall pulses while idle are ignored
    bus.i_fall = 8'hFF;
    tick();
    bus.i_fall = '0;
    chk("idle_fall_count", bus.o_count, 0);
    chk("idle_fall_nn",    bus.o_nn,    0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Timeout: k=7 with only two channels firing
    start_frame(7);
    sb_q.push_back(mk(7, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 2, 1, 1));
    c = 0;
    for (int cy = 1; cy <= 400; cy++) begin
      bus.i_fall = (cy == 1) ? 8'h02 : ((cy == 3) ? 8'h10 : 8'h00);
      tick();
      bus.i_fall = '0;
      c = cy;
      if (bus.o_done) break;
    end
    chk("tmo_armed_cycles", c, 255);
    if (bus.o_done) begin
      pop_check("tmo");
    end else begin
      chk("tmo_done_seen", 0, 1);
      void'(sb_q.pop_front());
    end
    tick();
    chk("tmo_done_single", bus.o_done,    0);
    chk("tmo_held",        bus.o_timeout, 1);

    // Re-arm mid-frame: aborted frame produces no done
    start_frame(3);
    chk("rearm_tmo_cleared", bus.o_timeout, 0);
    bus.i_fall = 8'h01; tick();
    bus.i_fall = 8'h02; tick();
    bus.i_fall = '0;
    chk("rearm_mid_count", bus.o_count, 2);
    chk("rearm_mid_nn",    bus.o_nn,    8'h01);
    start_frame(2);
    chk("rearm_done",  bus.o_done,  0);
    chk("rearm_count", bus.o_count, 0);
    chk("rearm_nn",    bus.o_nn,    0);
    chk("rearm_busy",  bus.o_busy,  1);
    sb_q.push_back(mk(2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h48, 2, 0, 6));
    bus.i_fall = 8'h40; tick();
    chk("rearm_done_early", bus.o_done, 0);
    bus.i_fall = 8'h08; tick();
    bus.i_fall = '0;
    chk("rearm_done_pulse", bus.o_done, 1);
    if (bus.o_done) pop_check("rearm");
    else void'(sb_q.pop_front());
    tick();
    chk("rearm_done_single", bus.o_done, 0);

    // Asynchronous reset mid-frame
    start_frame(3);
    bus.i_fall = 8'h05; tick();
    bus.i_fall = '0;
    chk("arst_mid_count", bus.o_count, 2);
    rst_n = 1'b0;
    #1;
    chk("arst_nn",    bus.o_nn,    0);
    chk("arst_count", bus.o_count, 0);
    chk("arst_busy",  bus.o_busy,  0);
    chk("arst_done",  bus.o_done,  0);
    repeat (2) begin
      tick();
      chk("arst_no_done", bus.o_done, 0);
    end
    rst_n = 1'b1;
    tick();
    chk("arst_release_busy", bus.o_busy, 0);
    chk("arst_release_done", bus.o_done, 0);
    run_vec(vecs[1], "post_arst");

    chk("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
